// File: rtl/nmr_bstrm_arb_encoder.sv
// Serial capture -> pattern / run-length / EOS command-word encoder with output FIFO.
// Latency: a full chunk is evaluated 2 cycles after completing; its words are pushed 1-2 cycles later.
// Backpressure: capture never stalls; a push into a full FIFO drops the word and sets sticky OVF.
// Optional build macro NMR_BSTRM_ENC_RUN_MERGE_EN enables all-1s/all-0s run detection and merging.

// Small synchronous FIFO; the head word reads as zero while the FIFO is empty.
module nmr_bstrm_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_drop,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             pop;
    logic             accept;

    assign head_vld  = (cnt != '0);
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign pop       = head_vld && pop_rdy;
    // A full FIFO still accepts a push in the cycle its head is popped.
    assign accept    = push_vld && (!full || pop);
    assign push_drop = push_vld && full && !pop;
    assign head_dat  = head_vld ? mem[rd_ptr] : '0;

    // Storage write; contents are only observable through the gated head.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module nmr_bstrm_arb_encoder #(
    parameter int DATA_WIDTH = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_pattern_mode,
    output logic                  wr_all_1_mode,
    output logic                  wr_all_0_mode,
    output logic                  wr_end_of_sequence,
    output logic                  WR_VALID,
    input  logic                  WR_READY
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int WW = DATA_WIDTH + 4;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        E_IDLE,
        E_EVAL,
        E_PUSH_RUN,
        E_PUSH_PAT,
        E_PUSH_EOS
    } enc_state_t;

    enc_state_t st;
    enc_state_t st_nxt;

    // Capture side
    logic                  busy;
    logic                  cap_on;
    logic [DATA_WIDTH-1:0] sr;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic                  hold_vld;
    logic                  fin_req;
    logic [DATA_WIDTH-1:0] tl_dat;
    logic [CW-1:0]         tl_k;
    logic                  ovf;

    logic                  start_acc;
    logic [DATA_WIDTH-1:0] sr_nxt;
    logic                  chunk_done;
    logic [CW-1:0]         k_nxt;
    logic [DATA_WIDTH-1:0] tl_nxt;

    // Encoder side
    logic [DATA_WIDTH-1:0] ev_dat;
    logic                  ev_fin;
    logic                  pat_pend;
    logic [DATA_WIDTH-1:0] pat_dat;
    logic                  eos_pend;
    logic                  hold_take;
    logic                  fin_take;
    logic                  d_pat;
    logic                  d_eos;

    // FIFO side
    logic                  push_vld;
    logic [WW-1:0]         push_dat;
    logic                  push_drop;
    logic                  head_vld;
    logic [WW-1:0]         head_dat;

`ifdef NMR_BSTRM_ENC_RUN_MERGE_EN
    localparam logic [DATA_WIDTH-1:0] ONES  = '1;
    localparam logic [DATA_WIDTH-1:0] W_LEN = DATA_WIDTH'(DATA_WIDTH);

    // Pending run and the (up to two) run words staged for pushing
    logic                  run_vld;
    logic                  run_val;
    logic [DATA_WIDTH-1:0] run_len;
    logic                  er_val;
    logic [DATA_WIDTH-1:0] er_len;
    logic                  er2_vld;
    logic                  er2_val;
    logic [DATA_WIDTH-1:0] er2_len;

    logic [DATA_WIDTH-1:0] k_len;
    logic [DATA_WIDTH-1:0] add_len;
    logic [DATA_WIDTH-1:0] t_mask;
    logic                  c_uni;
    logic                  c_b;
    logic                  match;
    logic                  d_run;
    logic                  d_run_val;
    logic [DATA_WIDTH-1:0] d_run_len;
    logic                  d_r2;
    logic                  n_run_vld;
    logic                  n_run_val;
    logic [DATA_WIDTH-1:0] n_run_len;
`endif

    assign start_acc  = START && !busy;
    assign sr_nxt     = {sr[DATA_WIDTH-2:0], IN};
    assign chunk_done = (cnt == LAST_BIT);
    assign k_nxt      = chunk_done ? '0 : cnt + 1'b1;
    // Partial tail bits left-aligned, zero-padded in the LSBs.
    assign tl_nxt     = chunk_done ? '0 : (sr_nxt << (DATA_WIDTH - int'(k_nxt)));
    assign hold_take  = (st == E_IDLE) && hold_vld;
    assign fin_take   = (st == E_IDLE) && !hold_vld && fin_req;

    // Capture shifter, chunk hand-off, STOP tail snapshot, BUSY and OVF flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy     <= 1'b0;
            cap_on   <= 1'b0;
            sr       <= '0;
            cnt      <= '0;
            hold_dat <= '0;
            hold_vld <= 1'b0;
            fin_req  <= 1'b0;
            tl_dat   <= '0;
            tl_k     <= '0;
            ovf      <= 1'b0;
        end else begin
            if (start_acc) begin
                busy   <= 1'b1;
                cap_on <= 1'b1;
                cnt    <= '0;
            end else if (st == E_PUSH_EOS) begin
                busy   <= 1'b0;
            end
            if (start_acc) begin
                ovf <= 1'b0;
            end else if (push_drop) begin
                ovf <= 1'b1;
            end
            if (hold_take) begin
                hold_vld <= 1'b0;
            end
            if (fin_take) begin
                fin_req <= 1'b0;
            end
            if (cap_on) begin
                sr  <= sr_nxt;
                cnt <= chunk_done ? '0 : cnt + 1'b1;
                if (chunk_done) begin
                    hold_dat <= sr_nxt;
                    hold_vld <= 1'b1;
                end
                if (STOP) begin
                    cap_on  <= 1'b0;
                    fin_req <= 1'b1;
                    tl_dat  <= tl_nxt;
                    tl_k    <= k_nxt;
                    cnt     <= '0;
                end
            end
        end
    end

`ifdef NMR_BSTRM_ENC_RUN_MERGE_EN
    // Evaluation decisions: merge, flush, start runs or emit patterns
    always_comb begin
        k_len     = DATA_WIDTH'(tl_k);
        add_len   = ev_fin ? k_len : W_LEN;
        t_mask    = ~(ONES >> tl_k);
        c_uni     = 1'b0;
        c_b       = 1'b0;
        d_run     = 1'b0;
        d_run_val = run_val;
        d_run_len = run_len;
        d_r2      = 1'b0;
        d_pat     = 1'b0;
        d_eos     = ev_fin;
        n_run_vld = run_vld;
        n_run_val = run_val;
        n_run_len = run_len;
        if (ev_fin) begin
            c_b   = (tl_k != '0) && ((ev_dat & t_mask) == t_mask);
            c_uni = c_b || ((tl_k != '0) && (ev_dat == '0));
        end else begin
            c_b   = &ev_dat;
            c_uni = c_b || (ev_dat == '0);
        end
        // A run only absorbs new bits while its length cannot overflow.
        match = run_vld && c_uni && (run_val == c_b) && (run_len <= ONES - add_len);
        if (!ev_fin) begin
            if (match) begin
                n_run_len = run_len + W_LEN;
            end else if (c_uni) begin
                d_run     = run_vld;
                n_run_vld = 1'b1;
                n_run_val = c_b;
                n_run_len = W_LEN;
            end else begin
                d_run     = run_vld;
                n_run_vld = 1'b0;
                d_pat     = 1'b1;
            end
        end else begin
            n_run_vld = 1'b0;
            if (tl_k == '0) begin
                d_run = run_vld;
            end else if (match) begin
                d_run     = 1'b1;
                d_run_len = run_len + k_len;
            end else if (c_uni && (tl_k >= CW'(3))) begin
                d_run = run_vld;
                d_r2  = 1'b1;
            end else begin
                d_run = run_vld;
                d_pat = 1'b1;
            end
        end
    end
`else
    // Without run merging every chunk and any non-empty tail is a pattern
    always_comb begin
        d_pat = !ev_fin || (tl_k != '0);
        d_eos = ev_fin;
    end
`endif

    // Encoder state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            st <= E_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Encoder next state and FIFO push word
    always_comb begin
        st_nxt   = st;
        push_vld = 1'b0;
        push_dat = '0;
        unique case (st)
            E_IDLE: begin
                if (hold_vld || fin_req) begin
                    st_nxt = E_EVAL;
                end
            end
            E_EVAL: begin
`ifdef NMR_BSTRM_ENC_RUN_MERGE_EN
                if (d_run || d_r2) begin
                    st_nxt = E_PUSH_RUN;
                end else
`endif
                if (d_pat) begin
                    st_nxt = E_PUSH_PAT;
                end else if (d_eos) begin
                    st_nxt = E_PUSH_EOS;
                end else begin
                    st_nxt = E_IDLE;
                end
            end
            E_PUSH_RUN: begin
`ifdef NMR_BSTRM_ENC_RUN_MERGE_EN
                push_vld = 1'b1;
                push_dat = {1'b0, er_val, ~er_val, 1'b0, er_len};
                if (er2_vld) begin
                    st_nxt = E_PUSH_RUN;
                end else if (pat_pend) begin
                    st_nxt = E_PUSH_PAT;
                end else if (eos_pend) begin
                    st_nxt = E_PUSH_EOS;
                end else begin
                    st_nxt = E_IDLE;
                end
`else
                st_nxt = E_IDLE;
`endif
            end
            E_PUSH_PAT: begin
                push_vld = 1'b1;
                push_dat = {4'b1000, pat_dat};
                st_nxt   = eos_pend ? E_PUSH_EOS : E_IDLE;
            end
            E_PUSH_EOS: begin
                push_vld = 1'b1;
                push_dat = {4'b0001, {DATA_WIDTH{1'b0}}};
                st_nxt   = E_IDLE;
            end
            default: st_nxt = E_IDLE;
        endcase
    end

    // Chunk under evaluation and the word plan produced by each evaluation
    always_ff @(posedge CLK) begin
        if (RST) begin
            ev_dat   <= '0;
            ev_fin   <= 1'b0;
            pat_pend <= 1'b0;
            pat_dat  <= '0;
            eos_pend <= 1'b0;
        end else begin
            if (hold_take) begin
                ev_dat <= hold_dat;
                ev_fin <= 1'b0;
            end else if (fin_take) begin
                ev_dat <= tl_dat;
                ev_fin <= 1'b1;
            end
            if (st == E_EVAL) begin
                pat_pend <= d_pat;
                pat_dat  <= ev_dat;
                eos_pend <= d_eos;
            end
        end
    end

`ifdef NMR_BSTRM_ENC_RUN_MERGE_EN
    // Pending run update and staging of run words to flush
    always_ff @(posedge CLK) begin
        if (RST) begin
            run_vld <= 1'b0;
            run_val <= 1'b0;
            run_len <= '0;
            er_val  <= 1'b0;
            er_len  <= '0;
            er2_vld <= 1'b0;
            er2_val <= 1'b0;
            er2_len <= '0;
        end else if (st == E_EVAL) begin
            run_vld <= n_run_vld;
            run_val <= n_run_val;
            run_len <= n_run_len;
            er2_val <= c_b;
            er2_len <= k_len;
            if (d_run) begin
                er_val  <= d_run_val;
                er_len  <= d_run_len;
                er2_vld <= d_r2;
            end else begin
                er_val  <= c_b;
                er_len  <= k_len;
                er2_vld <= 1'b0;
            end
        end else if ((st == E_PUSH_RUN) && er2_vld) begin
            er_val  <= er2_val;
            er_len  <= er2_len;
            er2_vld <= 1'b0;
        end
    end
`endif

    nmr_bstrm_arb_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .push_drop (push_drop),
        .pop_rdy   (WR_READY),
        .head_vld  (head_vld),
        .head_dat  (head_dat)
    );

    assign BUSY               = busy;
    assign DONE               = !busy && !head_vld;
    assign OVF                = ovf;
    assign WR_VALID           = head_vld;
    assign wr_data            = head_dat[DATA_WIDTH-1:0];
    assign wr_pattern_mode    = head_dat[DATA_WIDTH+3];
    assign wr_all_1_mode      = head_dat[DATA_WIDTH+2];
    assign wr_all_0_mode      = head_dat[DATA_WIDTH+1];
    assign wr_end_of_sequence = head_dat[DATA_WIDTH];
endmodule

// File: tb/tb_nmr_bstrm_arb_encoder.sv
// Bench for nmr_bstrm_arb_encoder: directed and randomized captures against a bit-list reference model.
// Latency: words are collected whenever they leave the FIFO; only order and content are compared.
// Backpressure: WR_READY is held high except in the overflow and reset scenarios.
module tb_nmr_bstrm_arb_encoder;
    localparam int W = 8;

    typedef logic [11:0] word_t;  // {pat, all1, all0, eos, data}

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         STOP;
    logic         IN;
    logic         BUSY;
    logic         DONE;
    logic         OVF;
    logic [W-1:0] wr_data;
    logic         wr_pattern_mode;
    logic         wr_all_1_mode;
    logic         wr_all_0_mode;
    logic         wr_end_of_sequence;
    logic         WR_VALID;
    logic         WR_READY;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    stim[$];
    word_t exp_q[$];
    word_t got_q[$];

    nmr_bstrm_arb_encoder #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .IN(IN),
        .BUSY(BUSY), .DONE(DONE), .OVF(OVF), .wr_data(wr_data),
        .wr_pattern_mode(wr_pattern_mode), .wr_all_1_mode(wr_all_1_mode),
        .wr_all_0_mode(wr_all_0_mode), .wr_end_of_sequence(wr_end_of_sequence),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t head_word();
        return {wr_pattern_mode, wr_all_1_mode, wr_all_0_mode, wr_end_of_sequence, wr_data};
    endfunction

    // Collect every word the writer accepts; the pop happens at the following rising edge.
    always @(negedge CLK) begin
        if (WR_VALID && WR_READY) begin
            got_q.push_back(head_word());
            chk("type_onehot", $countones({wr_pattern_mode, wr_all_1_mode,
                                           wr_all_0_mode, wr_end_of_sequence}), 1);
        end
    end

    function automatic void exp_run(input int b, input int len);
        exp_q.push_back({1'b0, b[0], ~b[0], 1'b0, 8'(len)});
    endfunction

    function automatic void exp_pat(input int v);
        exp_q.push_back({4'b1000, 8'(v)});
    endfunction

    // Reference: cut the captured bit list into W-bit chunks and apply the word rules.
    function automatic void build_exp();
        int n;
        int nf;
        int k;
        int v;
        int t;
        int ones;
        int rv;
        int rb;
        int rl;
        int b;
        bit uni;
        n  = stim.size();
        nf = n / W;
        k  = n % W;
        rv = 0;
        rb = 0;
        rl = 0;
        exp_q.delete();
        for (int c = 0; c < nf; c++) begin
            v = 0;
            for (int i = 0; i < W; i++) v = v * 2 + int'(stim[c*W+i]);
`ifdef NMR_BSTRM_ENC_RUN_MERGE_EN
            if (v == 255 || v == 0) begin
                b = (v == 255) ? 1 : 0;
                if (rv == 1 && rb == b && rl + W <= 255) begin
                    rl += W;
                end else begin
                    if (rv == 1) exp_run(rb, rl);
                    rv = 1;
                    rb = b;
                    rl = W;
                end
            end else begin
                if (rv == 1) exp_run(rb, rl);
                rv = 0;
                exp_pat(v);
            end
`else
            exp_pat(v);
`endif
        end
        t    = 0;
        ones = 0;
        for (int i = 0; i < k; i++) begin
            t    = t * 2 + int'(stim[nf*W+i]);
            ones = ones + int'(stim[nf*W+i]);
        end
        t = t << (W - k);
`ifdef NMR_BSTRM_ENC_RUN_MERGE_EN
        if (k == 0) begin
            if (rv == 1) exp_run(rb, rl);
        end else begin
            uni = (ones == k) || (ones == 0);
            b   = (ones == k) ? 1 : 0;
            if (uni && rv == 1 && rb == b && rl + k <= 255) begin
                exp_run(b, rl + k);
            end else if (uni && k >= 3) begin
                if (rv == 1) exp_run(rb, rl);
                exp_run(b, k);
            end else begin
                if (rv == 1) exp_run(rb, rl);
                exp_pat(t);
            end
        end
`else
        if (k > 0) exp_pat(t);
`endif
        exp_q.push_back(12'b0001_0000_0000);
    endfunction

    function automatic void add_bits(input int v, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back(bit'((v >> i) & 1));
    endfunction

    // START pulse, then one bit per cycle with STOP on the last bit.
    task automatic capture(input bit stop_with_start, input bit chk_start);
        @(posedge CLK); #1;
        START = 1'b1;
        STOP  = stop_with_start;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            IN   = stim[i];
            STOP = (i == stim.size() - 1);
            if (i == 0 && chk_start) begin
                @(negedge CLK);
                chk("ovf_cleared_by_start", OVF, 0);
                chk("busy_after_start", BUSY, 1);
            end
            @(posedge CLK); #1;
        end
        STOP = 1'b0;
        IN   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!(DONE && !BUSY) && cyc < 600);
        chk({tag, "_done"}, DONE, 1);
    endtask

    task automatic compare_words(input string tag, input int n);
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_case(input string tag, input bit stop_with_start);
        build_exp();
        got_q.delete();
        capture(stop_with_start, 1'b0);
        wait_done(tag);
        compare_words(tag, exp_q.size());
        chk({tag, "_ovf"}, OVF, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        word_t h0;
        RST = 1'b1; START = 1'b0; STOP = 1'b0; IN = 1'b0; WR_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 1);
        chk("rst_ovf", OVF, 0);
        chk("rst_wr_valid", WR_VALID, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_types", {wr_pattern_mode, wr_all_1_mode, wr_all_0_mode, wr_end_of_sequence}, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        stim.delete(); add_bits(24'hFFFFFF, 24);                      run_case("ones24", 0);
        stim.delete(); add_bits(8'hA5, 8); add_bits(0, 16);           run_case("a5_zeros", 1);
        stim.delete(); add_bits(16'hFFFF, 16); add_bits(8'hF0, 8);    run_case("ones_f0", 0);
        stim.delete(); add_bits(8'hFF, 8); add_bits(2'b11, 2);        run_case("tail_merge", 0);
        stim.delete(); add_bits(8'h3C, 8); add_bits(2'b10, 2);        run_case("tail_pat", 0);
        stim.delete(); add_bits(8'h00, 8); add_bits(3'b111, 3);       run_case("tail_run", 0);
        stim.delete(); add_bits(1, 1);                                run_case("one_bit", 0);
        stim.delete();
        for (int i = 0; i < 40; i++) add_bits(8'hFF, 8);
        add_bits(2'b11, 2);                                           run_case("saturate", 0);

        // Overflow: writer stalled through six mixed chunks
        WR_READY = 1'b0;
        stim.delete();
        for (int i = 0; i < 6; i++) add_bits(int'($urandom_range(1, 254)), 8);
        build_exp();
        got_q.delete();
        capture(1'b0, 1'b0);
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (BUSY && cyc < 200);
        chk("ovf_busy_fell", BUSY, 0);
        chk("ovf_set", OVF, 1);
        chk("ovf_wr_valid", WR_VALID, 1);
        chk("ovf_done_low", DONE, 0);
        h0 = exp_q[0];
        repeat (3) begin
            @(negedge CLK);
            chk("ovf_head_stable", head_word(), h0);
        end
        @(posedge CLK); #1;
        WR_READY = 1'b1;
        wait_done("ovf_drain");
        compare_words("ovf", 4);
        stim.delete(); add_bits(8'h5A, 8);
        build_exp();
        got_q.delete();
        capture(1'b0, 1'b1);
        wait_done("after_ovf");
        compare_words("after_ovf", exp_q.size());

        // Reset mid-capture discards queued words and aborts the capture
        WR_READY = 1'b0;
        got_q.delete();
        @(posedge CLK); #1; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        stim.delete(); add_bits(8'hA5, 8); add_bits(8'h3C, 8); add_bits(4'h9, 4);
        for (int i = 0; i < stim.size(); i++) begin
            IN = stim[i];
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        chk("pre_rst_wr_valid", WR_VALID, 1);
        @(posedge CLK); #1; RST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_done", DONE, 1);
        chk("midrst_ovf", OVF, 0);
        chk("midrst_wr_valid", WR_VALID, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_types", {wr_pattern_mode, wr_all_1_mode, wr_all_0_mode, wr_end_of_sequence}, 0);
        WR_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge CLK); #1;
            IN   = 1'($urandom_range(0, 1));
            STOP = (i == 15);
        end
        @(posedge CLK); #1; STOP = 1'b0;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("midrst_no_words", got_q.size(), 0);
        chk("midrst_still_idle", BUSY, 0);

        // Randomized captures built from uniform and mixed segments
        for (int n = 0; n < 40; n++) begin
            int nseg;
            int kind;
            int len;
            stim.delete();
            nseg = int'($urandom_range(1, 5));
            for (int s = 0; s < nseg; s++) begin
                kind = int'($urandom_range(0, 2));
                len  = int'($urandom_range(1, 30));
                for (int i = 0; i < len; i++) begin
                    if (kind == 2) stim.push_back(1'($urandom_range(0, 1)));
                    else stim.push_back(kind[0]);
                end
            end
            run_case($sformatf("rnd%0d", n), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nmr_bstrm_arb_encoder.md
# nmr_bstrm_arb_encoder

Captures a live serial bitstream and compresses it into the command-word format consumed by the arbitrary bitstream datapath: pattern words, all-1s/all-0s run-length words, and an end-of-sequence word. It sits on a capture pin, such as a loop-back of the NMR TX/RX gate line or an external trigger line. It writes words through a small FIFO to an SRAM writer. Replaying its output through the bitstream datapath reproduces the captured stream cycle-for-cycle, except for the documented padding of a short tail.

## Interface
- DATA_WIDTH, 120, command word width and pattern length in bits; minimum 8.
- FIFO_DEPTH, 4, output word FIFO depth; power of two, minimum 2.
- CLK  in  1  sole clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse that begins a capture; ignored while BUSY.
- STOP  in  1  single-cycle pulse that ends a capture; ignored while idle.
- IN  in  1  serial bit, sampled every cycle during capture.
- BUSY  out  1  high from the cycle after START until the EOS word is pushed.
- DONE  out  1  high when idle and the FIFO is empty.
- OVF  out  1  sticky flag: a word was dropped because the FIFO was full; cleared by START.
- wr_data  out  DATA_WIDTH  pattern (MSB first) or run length in cycles.
- wr_pattern_mode / wr_all_1_mode / wr_all_0_mode / wr_end_of_sequence  out  1 each  one-hot word type.
- WR_VALID  out  1  FIFO head valid.
- WR_READY  in  1  writer accepts the head word when high together with WR_VALID.

## Operation
- Capture shifter: IN is sampled from cycle START+1 through the STOP cycle inclusive. Bits shift MSB-first into a DATA_WIDTH chunk register with a bit counter.
- On a full chunk, the chunk is copied to a hold register and the counter restarts. Capture never stalls.
- Encoder FSM states: E_IDLE, E_EVAL, E_PUSH_RUN, E_PUSH_PAT, E_PUSH_EOS.
- E_IDLE → E_EVAL when a chunk is held, or on the final (STOP) evaluation.
- E_EVAL, when the chunk is uniform with value b:
  - If a pending run of value b exists, add DATA_WIDTH to its length.
  - Otherwise, flush any pending run (E_PUSH_RUN), then start a pending run of b with length DATA_WIDTH.
- E_EVAL, when the chunk is mixed: E_PUSH_RUN if a run is pending, then E_PUSH_PAT.
- Each push state pushes one word per cycle and returns to E_IDLE.
- Final evaluation, taken when STOP is seen, with k bits in the partial chunk (0 ≤ k < DATA_WIDTH):
  - k=0: flush the pending run, then push EOS.
  - Partial bits uniform with value b, and a pending run of b exists: add k to the run, flush it, push EOS.
  - Partial bits uniform, no matching run, and k ≥ 3: flush any other run, push a run of length k, push EOS.
  - Otherwise: flush any run, push a pattern of the k bits left-aligned and zero-padded in the LSBs, push EOS.
- Run length minimum is 3, the datapath minimum. A run is emitted only with length ≥ 3.
- Run length saturation: if adding DATA_WIDTH would exceed 2^DATA_WIDTH−1, flush the run first, then restart it.
- The EOS word has wr_data=0. After EOS, BUSY falls.

## Timing
- Reset values:
  - BUSY=0, DONE=1, OVF=0, WR_VALID=0.
  - wr_data=0 and all four type bits=0.
  - FIFO empty, FSM in E_IDLE, pending run cleared.
- RST mid-capture aborts everything. No EOS is emitted and queued words are discarded.
- A chunk is evaluated within 3 cycles of completing. The next chunk cannot complete sooner, because DATA_WIDTH ≥ 8.
- Push with the FIFO full: the word is dropped and OVF is set. Simultaneous push and pop with the FIFO full is allowed and drops nothing.
- WR_VALID is asserted the cycle after the first push. The head word is held stable while WR_VALID=1 and WR_READY=0.
- STOP coincident with the last bit of a chunk: the chunk is evaluated as full, then the final evaluation runs with k=0.
- START and STOP in the same cycle while idle: capture starts, STOP is ignored.

## Configuration
- NMR_BSTRM_ENC_RUN_MERGE_EN defined: run detection and merging as above.
- Undefined: every full chunk is pushed as a pattern word, and the tail is always emitted as a zero-padded pattern. Run-type words are never produced, and the run-length adder and saturation logic are not built.

## Test plan
Bench uses DATA_WIDTH=8, FIFO_DEPTH=4, WR_READY=1 unless stated.
- 24 cycles IN=1, then STOP on the 24th → all_1 word data=24, then EOS. With the macro off → three patterns 0xFF, then EOS.
- Chunk 0xA5, then 16 zeros, STOP → pattern 0xA5, all_0 data=16, EOS.
- 16 ones, then chunk 0xF0, STOP → all_1 data=16, pattern 0xF0, EOS.
- Tail handling:
  - 8 ones, then 2 ones, STOP → all_1 data=10, EOS.
  - Chunk 0x3C, then bits 1,0, STOP → pattern 0x3C, pattern 0x80, EOS.
- WR_READY=0 throughout 6 mixed chunks → FIFO holds the first 4 words, OVF=1. A new START clears OVF.
- RST asserted mid-capture → all outputs at reset values the next cycle, no words emitted, DONE=1.
